// File: rtl/axilite_mmio_uart.sv
// AXI4-Lite UART-Lite-style register window: RX/TX byte FIFOs, STAT and CTRL registers,
// with valid/ready byte streams toward the console and a level interrupt.
module axilite_mmio_uart #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                    uncoreclk,
   input  logic                    uncore_rstn,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [2:0]              s_axi_awprot,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [2:0]              s_axi_arprot,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    rx_ready,
   output logic                    intr
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic          aw_held, w_held, w_strb0, bvalid, rvalid, err, intr_en;
   logic [1:0]    aw_sel;
   logic [7:0]    w_byte;
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
   logic [CW-1:0] tx_count, rx_count;

   logic       do_wr, wr_tx, wr_ctrl, tx_push, tx_drop, tx_pop, tx_flush;
   logic       rx_push, rx_pop, rx_flush, tx_full, tx_empty, rx_full, rx_empty;
   logic       ar_hs, rd_rx, rd_stat;
   logic [5:0] stat;
   logic       unused_bits;

   assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr,
                          s_axi_wdata, s_axi_wstrb};

   assign tx_full  = (tx_count == FULL);
   assign tx_empty = (tx_count == '0);
   assign rx_full  = (rx_count == FULL);
   assign rx_empty = (rx_count == '0);

   // A write takes effect the cycle after both address and data are held.
   assign do_wr    = aw_held && w_held;
   assign wr_tx    = do_wr && (aw_sel == 2'd1) && w_strb0;
   assign wr_ctrl  = do_wr && (aw_sel == 2'd3) && w_strb0;
   assign tx_push  = wr_tx && !tx_full;
   assign tx_drop  = wr_tx && tx_full;
   assign tx_flush = wr_ctrl && w_byte[0];
   assign rx_flush = wr_ctrl && w_byte[1];
   assign tx_pop   = !tx_empty && tx_ready;

   assign ar_hs   = s_axi_arvalid && !rvalid;
   assign rd_rx   = ar_hs && (s_axi_araddr[3:2] == 2'd0);
   assign rd_stat = ar_hs && (s_axi_araddr[3:2] == 2'd2);
   assign rx_pop  = rd_rx && !rx_empty;
   assign rx_push = rx_valid && !rx_full;

   assign stat = {err, intr_en, tx_full, tx_empty, rx_full, !rx_empty};

   assign s_axi_awready = !aw_held && !bvalid;
   assign s_axi_wready  = !w_held && !bvalid;
   assign s_axi_bvalid  = bvalid;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_arready = !rvalid;
   assign s_axi_rvalid  = rvalid;
   assign s_axi_rresp   = 2'b00;
   assign tx_valid      = !tx_empty;
   assign tx_data       = tx_mem[tx_rd];
   assign rx_ready      = !rx_full;

   always_ff @(posedge uncoreclk) begin
      if (!uncore_rstn) begin
         aw_held     <= 1'b0;
         w_held      <= 1'b0;
         bvalid      <= 1'b0;
         rvalid      <= 1'b0;
         s_axi_rdata <= '0;
         err         <= 1'b0;
         intr_en     <= 1'b0;
         intr        <= 1'b0;
         tx_wr       <= '0;
         tx_rd       <= '0;
         tx_count    <= '0;
         rx_wr       <= '0;
         rx_rd       <= '0;
         rx_count    <= '0;
      end else begin
         if (s_axi_awvalid && s_axi_awready) aw_held <= 1'b1;
         if (s_axi_wvalid && s_axi_wready)   w_held  <= 1'b1;
         if (do_wr) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
         end else if (bvalid && s_axi_bready) begin
            bvalid <= 1'b0;
         end

         if (ar_hs) begin
            rvalid <= 1'b1;
            unique case (s_axi_araddr[3:2])
               2'd0:    s_axi_rdata <= rx_empty ? '0 : DATA_WIDTH'(rx_mem[rx_rd]);
               2'd2:    s_axi_rdata <= DATA_WIDTH'(stat);
               default: s_axi_rdata <= '0;
            endcase
         end else if (rvalid && s_axi_rready) begin
            rvalid <= 1'b0;
         end

         // A dropped TX byte wins over the clear-on-read of the same cycle.
         if (tx_drop)      err <= 1'b1;
         else if (rd_stat) err <= 1'b0;
         if (wr_ctrl) intr_en <= w_byte[4];
         intr <= intr_en && (!rx_empty || tx_empty);

         if (tx_flush) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
         end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
            else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
         end

         if (rx_flush) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
         end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
            else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
         end
      end
   end

   // Captured request fields and FIFO storage carry no reset.
   always_ff @(posedge uncoreclk) begin
      if (s_axi_awvalid && s_axi_awready) aw_sel <= s_axi_awaddr[3:2];
      if (s_axi_wvalid && s_axi_wready) begin
         w_byte  <= s_axi_wdata[7:0];
         w_strb0 <= s_axi_wstrb[0];
      end
      if (tx_push) tx_mem[tx_wr] <= w_byte;
      if (rx_push) rx_mem[rx_wr] <= rx_data;
   end
endmodule

// File: tb/tb_axilite_mmio_uart.sv
// Directed bench for axilite_mmio_uart: register map, FIFO limits, AXI-Lite handshakes, reset.
module tb_axilite_mmio_uart;
   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready, intr;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd;

   axilite_mmio_uart #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
      .uncoreclk(clk), .uncore_rstn(rstn),
      .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .intr(intr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      int n = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         if (awvalid && awready) aw_done = 1'b1;
         if (wvalid && wready)   w_done  = 1'b1;
         tick();
         n++;
         if (aw_done) awvalid = 1'b0;
         if (w_done)  wvalid  = 1'b0;
      end
      n = 0;
      while (!bvalid && n < 20) begin
         tick();
         n++;
      end
      check("write_bvalid", {31'b0, bvalid}, 32'd1);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
      int n = 0;
      araddr = a; arvalid = 1'b1;
      while (!arready && n < 20) begin
         tick();
         n++;
      end
      tick();
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin
         tick();
         n++;
      end
      check("read_rvalid", {31'b0, rvalid}, 32'd1);
      d = rdata;
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      tick();
      tick();
      check("rst_awready", {31'b0, awready}, 32'd1);
      check("rst_wready", {31'b0, wready}, 32'd1);
      check("rst_arready", {31'b0, arready}, 32'd1);
      check("rst_bvalid", {31'b0, bvalid}, 32'd0);
      check("rst_rvalid", {31'b0, rvalid}, 32'd0);
      check("rst_txvalid", {31'b0, tx_valid}, 32'd0);
      check("rst_rxready", {31'b0, rx_ready}, 32'd1);
      check("rst_intr", {31'b0, intr}, 32'd0);
      rstn = 1'b1;
      tick();

      // Test 1: AW one cycle before W
      awaddr = 32'h4; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      wdata = 32'h41; wstrb = 4'h1; wvalid = 1'b1;
      check("t1_wready", {31'b0, wready}, 32'd1);
      tick();
      wvalid = 1'b0;
      check("t1_bvalid_early", {31'b0, bvalid}, 32'd0);
      tick();
      check("t1_bvalid", {31'b0, bvalid}, 32'd1);
      check("t1_bresp", {30'b0, bresp}, 32'd0);
      check("t1_txvalid", {31'b0, tx_valid}, 32'd1);
      check("t1_txdata", {24'b0, tx_data}, 32'h41);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check("t1_bvalid_clr", {31'b0, bvalid}, 32'd0);
      check("t1_awready", {31'b0, awready}, 32'd1);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check("t1_tx_drained", {31'b0, tx_valid}, 32'd0);
      axi_write(32'h4, 32'h33, 4'hE);
      check("t1_strb0_off", {31'b0, tx_valid}, 32'd0);

      // Test 2: overfill TX
      for (int i = 0; i < 17; i++) axi_write(32'h4, 32'h50 + i, 4'hF);
      axi_read(32'h8, rd);
      check("t2_stat_err", rd, 32'h28);
      axi_read(32'h8, rd);
      check("t2_stat_clr", rd, 32'h08);
      axi_read(32'h4, rd);
      check("t2_read_tx", rd, 32'h0);
      tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("t2_tx_order", {24'b0, tx_data}, 32'h50 + i);
         tick();
      end
      tx_ready = 1'b0;
      check("t2_tx_empty", {31'b0, tx_valid}, 32'd0);

      // Test 3: fill RX from the stream, read it back
      rx_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rx_data = 8'h10 + 8'(i);
         check("t3_rxready", {31'b0, rx_ready}, 32'd1);
         tick();
      end
      rx_data = 8'h20;
      check("t3_rx_full", {31'b0, rx_ready}, 32'd0);
      tick();
      rx_valid = 1'b0;
      axi_read(32'h8, rd);
      check("t3_stat_full", rd, 32'h07);
      for (int i = 0; i < 16; i++) begin
         axi_read(32'h0, rd);
         check("t3_rx_order", rd, 32'h10 + i);
      end
      axi_read(32'h0, rd);
      check("t3_rx_empty_read", rd, 32'h0);
      axi_read(32'h8, rd);
      check("t3_stat_empty", rd, 32'h04);

      // Test 4: flush both FIFOs and enable the interrupt
      for (int i = 0; i < 3; i++) axi_write(32'h4, 32'h60 + i, 4'h1);
      rx_valid = 1'b1; rx_data = 8'hA0;
      tick();
      tick();
      rx_valid = 1'b0;
      awaddr = 32'hC; wdata = 32'h13; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      check("t4_intr_pre", {31'b0, intr}, 32'd0);
      tick();
      check("t4_intr_lag", {31'b0, intr}, 32'd0);
      check("t4_txvalid", {31'b0, tx_valid}, 32'd0);
      tick();
      check("t4_intr_rise", {31'b0, intr}, 32'd1);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      axi_read(32'h8, rd);
      check("t4_stat", rd, 32'h14);

      // Test 5: concurrent read and write with responses back-pressured
      araddr = 32'h8; arvalid = 1'b1;
      awaddr = 32'h4; wdata = 32'h77; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t5_rvalid", {31'b0, rvalid}, 32'd1);
         check("t5_rdata", rdata, 32'h14);
         check("t5_bvalid", {31'b0, bvalid}, 32'd1);
         check("t5_ready", {29'b0, arready, awready, wready}, 32'd0);
         tick();
      end
      check("t5_txdata", {23'b0, tx_valid, tx_data}, 32'h177);
      rready = 1'b1; bready = 1'b1;
      tick();
      rready = 1'b0; bready = 1'b0;
      check("t5_done_valid", {30'b0, rvalid, bvalid}, 32'd0);
      check("t5_done_ready", {29'b0, arready, awready, wready}, 32'h7);

      // Test 6: reset with a write response pending and both FIFOs nonempty
      rx_valid = 1'b1; rx_data = 8'h99;
      tick();
      rx_valid = 1'b0;
      awaddr = 32'h4; wdata = 32'h55; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      check("t6_pre_bvalid", {31'b0, bvalid}, 32'd1);
      check("t6_pre_intr", {31'b0, intr}, 32'd1);
      rstn = 1'b0;
      tick();
      check("t6_ready", {29'b0, awready, wready, arready}, 32'h7);
      check("t6_valid", {30'b0, bvalid, rvalid}, 32'd0);
      check("t6_rdata", rdata, 32'h0);
      check("t6_txvalid", {31'b0, tx_valid}, 32'd0);
      check("t6_rxready", {31'b0, rx_ready}, 32'd1);
      check("t6_intr", {31'b0, intr}, 32'd0);
      rstn = 1'b1;
      tick();
      axi_read(32'h8, rd);
      check("t6_stat", rd, 32'h04);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
